// File: rtl/seq_dp_pkg.sv
// seq_dp_pkg: shared types for the seq_data_path datapath.
//   op_e         - 4-bit ALU command codes; codes at or above OP_NOP_FIRST are NOPs
//   state_e      - microsequencer T-steps
//   is_mul_div() - true for the iterative (multi-cycle) commands
//   is_nop()     - true for command codes that write nothing
package seq_dp_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_SHL = 4'd4,
      OP_SHR = 4'd5,
      OP_ROL = 4'd6,
      OP_ROR = 4'd7,
      OP_NEG = 4'd8,
      OP_NOT = 4'd9,
      OP_MUL = 4'd10,
      OP_DIV = 4'd11
   } op_e;

   localparam logic [3:0] OP_NOP_FIRST = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_EXEC = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5
   } state_e;

   function automatic logic is_mul_div(input logic [3:0] op_code);
      return (op_code == OP_MUL) || (op_code == OP_DIV);
   endfunction

   function automatic logic is_nop(input logic [3:0] op_code);
      return (op_code >= OP_NOP_FIRST);
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply (shift-add) and divide (restoring).
//   i_clock, i_clear : clock and synchronous active-high reset
//   i_load           : capture operands and start WIDTH iterations
//   i_is_div         : 1 = divide i_a / i_b, 0 = multiply i_a * i_b
//   i_a, i_b         : operands (multiplier/dividend, multiplicand/divisor)
//   o_done           : high during the cycle whose closing edge performs the last iteration
//   o_hi, o_lo       : product {hi,lo}, or remainder (hi) / quotient (lo)
module mul_div_unit
   import seq_dp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic             r_run;
   logic             r_div;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_m;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_prod;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_next_hi;
   logic [WIDTH-1:0] w_next_lo;

   // One iteration of either algorithm, selected by the latched mode.
   always_comb begin
      w_sum   = {1'b0, r_hi} + {1'b0, r_m};
      w_prod  = r_lo[0] ? w_sum : {1'b0, r_hi};
      // Restoring division: shift the next dividend bit into the partial remainder.
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_ge    = (w_shift >= {1'b0, r_m});
      // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
      w_diff  = w_shift[WIDTH-1:0] - r_m;
      if (r_div) begin
         if (w_ge) begin
            w_next_hi = w_diff;
         end else begin
            w_next_hi = w_shift[WIDTH-1:0];
         end
         w_next_lo = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_next_hi = w_prod[WIDTH:1];
         w_next_lo = {w_prod[0], r_lo[WIDTH-1:1]};
      end
   end

   // Operand capture, iteration counter and accumulator pair.
   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_run <= 1'b0;
         r_div <= 1'b0;
         r_cnt <= {CW{1'b0}};
         r_hi  <= {WIDTH{1'b0}};
         r_lo  <= {WIDTH{1'b0}};
         r_m   <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_run <= 1'b1;
         r_div <= i_is_div;
         r_cnt <= {CW{1'b0}};
         r_hi  <= {WIDTH{1'b0}};
         r_lo  <= i_a;
         r_m   <= i_b;
      end else if (r_run) begin
         r_hi  <= w_next_hi;
         r_lo  <= w_next_lo;
         r_cnt <= r_cnt + CW'(1);
         if (r_cnt == CNT_LAST) begin
            r_run <= 1'b0;
         end
      end
   end

   assign o_done = r_run && (r_cnt == CNT_LAST);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/seq_data_path.sv
// seq_data_path: bus-based register datapath with a microsequencer executing
// rc = ra OP rb in T-steps (T1 Y<-R[ra], T2 Z<-ALU(Y,R[rb]), T3 R[rc]<-Zlow,
// T4 HI<-Zhigh for MUL/DIV, with an EXEC phase of WIDTH cycles for MUL/DIV).
//   clock, clear      : clock, synchronous active-high reset
//   start, op         : command request (accepted in IDLE) and operation code
//   ra, rb, rc        : source A, source B, destination register selects
//   busy, done        : non-IDLE indicator, one-cycle completion pulse
//   ld_en/ld_sel/ld_data : external register load, honoured only in IDLE
//   rd_sel, rd_data   : combinational debug read port
//   hi, lo            : HI/LO registers
//   bus_out           : current shared-bus value (0 when undriven)
module seq_data_path
   import seq_dp_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NREGS = 16,
   localparam int RSEL  = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [RSEL-1:0]  ra,
   input  logic [RSEL-1:0]  rb,
   input  logic [RSEL-1:0]  rc,
   output logic             busy,
   output logic             done,
   input  logic             ld_en,
   input  logic [RSEL-1:0]  ld_sel,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [RSEL-1:0]  rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] bus_out
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW:0] W_VAL = (SW+1)'(WIDTH);

   state_e           r_state;
   state_e           w_next_state;
   logic             r_busy;
   logic             r_done;
   logic             w_next_done;
   logic [3:0]       r_op;
   logic [RSEL-1:0]  r_ra;
   logic [RSEL-1:0]  r_rb;
   logic [RSEL-1:0]  r_rc;
   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_y;
   logic [2*WIDTH-1:0] r_z;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_bus;
   logic [WIDTH-1:0] w_alu;
   logic [SW-1:0]    w_amt;
   logic [SW:0]      w_ramt;
   logic             w_is_md;
   logic             w_md_load;
   logic             w_md_done;
   logic [WIDTH-1:0] w_md_hi;
   logic [WIDTH-1:0] w_md_lo;
   logic [WIDTH-1:0] w_z_low;
   logic [WIDTH-1:0] w_z_high;

   assign w_is_md = is_mul_div(r_op);
   // For MUL/DIV the Z pair lives inside the iterative unit's accumulators.
   assign w_z_low  = w_is_md ? w_md_lo : r_z[WIDTH-1:0];
   assign w_z_high = w_is_md ? w_md_hi : r_z[2*WIDTH-1:WIDTH];

   mul_div_unit #(
      .WIDTH (WIDTH)
   ) u_mul_div (
      .i_clock  (clock),
      .i_clear  (clear),
      .i_load   (w_md_load),
      .i_is_div (r_op == OP_DIV),
      .i_a      (r_y),
      .i_b      (w_bus),
      .o_done   (w_md_done),
      .o_hi     (w_md_hi),
      .o_lo     (w_md_lo)
   );

   // Microsequencer state register and registered status flags.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= w_next_done;
      end
   end

   // Next-state decode, bus source selection and unit start strobe.
   always_comb begin
      w_next_state = r_state;
      w_bus        = {WIDTH{1'b0}};
      w_md_load    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_T1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_T1: begin
            w_bus        = r_regs[r_ra];
            w_next_state = ST_T2;
         end
         ST_T2: begin
            w_bus = r_regs[r_rb];
            if (w_is_md) begin
               w_md_load    = 1'b1;
               w_next_state = ST_EXEC;
            end else begin
               w_next_state = ST_T3;
            end
         end
         ST_EXEC: begin
            if (w_md_done) begin
               w_next_state = ST_T3;
            end else begin
               w_next_state = ST_EXEC;
            end
         end
         ST_T3: begin
            w_bus = w_z_low;
            if (w_is_md) begin
               w_next_state = ST_T4;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_T4: begin
            w_bus        = w_z_high;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
      // done is registered, so it is decoded from the state being entered.
      w_next_done = (w_next_state == ST_T4) ||
                    ((w_next_state == ST_T3) && !w_is_md);
   end

   // Single-cycle ALU: A operand is Y, B operand is the bus.
   always_comb begin
      w_amt  = w_bus[SW-1:0];
      w_ramt = W_VAL - {1'b0, w_amt};
      case (r_op)
         OP_ADD:  w_alu = r_y + w_bus;
         OP_SUB:  w_alu = r_y - w_bus;
         OP_AND:  w_alu = r_y & w_bus;
         OP_OR:   w_alu = r_y | w_bus;
         OP_SHL:  w_alu = r_y << w_amt;
         OP_SHR:  w_alu = r_y >> w_amt;
         // A zero amount gives a complementary shift of WIDTH, which yields 0.
         OP_ROL:  w_alu = (r_y << w_amt) | (r_y >> w_ramt);
         OP_ROR:  w_alu = (r_y >> w_amt) | (r_y << w_ramt);
         OP_NEG:  w_alu = {WIDTH{1'b0}} - r_y;
         OP_NOT:  w_alu = ~r_y;
         default: w_alu = {WIDTH{1'b0}};
      endcase
   end

   // Register file, command latch, Y, Z, HI and LO updates.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= {WIDTH{1'b0}};
         end
         r_op <= 4'd0;
         r_ra <= {RSEL{1'b0}};
         r_rb <= {RSEL{1'b0}};
         r_rc <= {RSEL{1'b0}};
         r_y  <= {WIDTH{1'b0}};
         r_z  <= {(2*WIDTH){1'b0}};
         r_hi <= {WIDTH{1'b0}};
         r_lo <= {WIDTH{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ld_en) begin
                  r_regs[ld_sel] <= ld_data;
               end
               if (start) begin
                  r_op <= op;
                  r_ra <= ra;
                  r_rb <= rb;
                  r_rc <= rc;
               end
            end
            ST_T1: begin
               r_y <= w_bus;
            end
            ST_T2: begin
               if (!w_is_md) begin
                  r_z <= {{WIDTH{1'b0}}, w_alu};
               end
            end
            ST_T3: begin
               if (!is_nop(r_op)) begin
                  r_regs[r_rc] <= w_bus;
               end
               if (w_is_md) begin
                  r_lo <= w_bus;
               end
            end
            ST_T4: begin
               r_hi <= w_bus;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bus_out = w_bus;
   assign rd_data = r_regs[rd_sel];
   assign hi      = r_hi;
   assign lo      = r_lo;

endmodule
